// File: rtl/hamming_decode_arbiter.sv
// Round-robin arbiter feeding one shared SECDED(8,4) decoder with a held output register.
// Define HAMMING_ARB_ERR_CNT_EN to build the saturating single/double error counters.
module hamming_decode_arbiter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [7:0]       a_code,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [7:0]       b_code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_src,
  output logic [7:0]       out_code,
  output logic [3:0]       out_data,
  output logic [1:0]       out_flag,
  output logic [2:0]       out_loc,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] sec_cnt,
  output logic [CNT_W-1:0] ded_cnt
);

  typedef enum logic [1:0] {IDLE, DEC, OUT} state_t;

  state_t     state_q, state_d;
  logic       last_q, last_d;
  logic [7:0] in_reg_q, in_reg_d;
  logic       src_q, src_d;
  logic [7:0] out_code_q, out_code_d;
  logic [1:0] out_flag_q, out_flag_d;
  logic [2:0] out_loc_q, out_loc_d;
  logic       out_src_q, out_src_d;

  logic       gnt_a, gnt_b;
  logic [2:0] syn;
  logic       sp;
  logic [7:0] dec_code;
  logic [1:0] dec_flag;
  logic [2:0] dec_loc;

  // Tie goes to whichever requester was not served last.
  assign gnt_a   = a_valid & (~b_valid | last_q);
  assign gnt_b   = b_valid & (~a_valid | ~last_q);
  assign a_ready = (state_q == IDLE) & gnt_a;
  assign b_ready = (state_q == IDLE) & gnt_b;

  assign syn[0] = in_reg_q[0] ^ in_reg_q[2] ^ in_reg_q[4] ^ in_reg_q[6];
  assign syn[1] = in_reg_q[1] ^ in_reg_q[2] ^ in_reg_q[5] ^ in_reg_q[6];
  assign syn[2] = in_reg_q[3] ^ in_reg_q[4] ^ in_reg_q[5] ^ in_reg_q[6];
  assign sp     = ^in_reg_q;

  always_comb begin
    dec_code = in_reg_q;
    dec_flag = 2'b00;
    dec_loc  = 3'd0;
    if (sp) begin
      dec_flag = 2'b01;
      dec_loc  = syn;
      if (syn == 3'd0) dec_code[7] = ~in_reg_q[7];
      else             dec_code[syn - 3'd1] = ~in_reg_q[syn - 3'd1];
    end else if (syn != 3'd0) begin
      dec_flag = 2'b10;
    end
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    in_reg_d   = in_reg_q;
    src_d      = src_q;
    out_code_d = out_code_q;
    out_flag_d = out_flag_q;
    out_loc_d  = out_loc_q;
    out_src_d  = out_src_q;
    case (state_q)
      IDLE: begin
        if (gnt_a || gnt_b) begin
          in_reg_d = gnt_a ? a_code : b_code;
          src_d    = gnt_b;
          last_d   = gnt_b;
          state_d  = DEC;
        end
      end
      DEC: begin
        out_code_d = dec_code;
        out_flag_d = dec_flag;
        out_loc_d  = dec_loc;
        out_src_d  = src_q;
        state_d    = OUT;
      end
      OUT: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      in_reg_q   <= 8'd0;
      src_q      <= 1'b0;
      out_code_q <= 8'd0;
      out_flag_q <= 2'b00;
      out_loc_q  <= 3'd0;
      out_src_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      in_reg_q   <= in_reg_d;
      src_q      <= src_d;
      out_code_q <= out_code_d;
      out_flag_q <= out_flag_d;
      out_loc_q  <= out_loc_d;
      out_src_q  <= out_src_d;
    end
  end

  assign out_valid = (state_q == OUT);
  assign out_src   = out_src_q;
  assign out_code  = out_code_q;
  assign out_data  = {out_code_q[6], out_code_q[5], out_code_q[4], out_code_q[2]};
  assign out_flag  = out_flag_q;
  assign out_loc   = out_loc_q;

`ifdef HAMMING_ARB_ERR_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] sec_q, sec_d;
  logic [CNT_W-1:0] ded_q, ded_d;

  // Clear has priority over a same-cycle increment.
  always_comb begin
    sec_d = sec_q;
    ded_d = ded_q;
    if (state_q == DEC) begin
      if (dec_flag == 2'b01 && sec_q != '1) sec_d = sec_q + CNT_ONE;
      if (dec_flag == 2'b10 && ded_q != '1) ded_d = ded_q + CNT_ONE;
    end
    if (cnt_clr) begin
      sec_d = '0;
      ded_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sec_q <= '0;
      ded_q <= '0;
    end else begin
      sec_q <= sec_d;
      ded_q <= ded_d;
    end
  end

  assign sec_cnt = sec_q;
  assign ded_cnt = ded_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign sec_cnt = '0;
  assign ded_cnt = '0;
`endif

endmodule

// File: tb/tb_hamming_decode_arbiter.sv
// Randomized bench for hamming_decode_arbiter against an encode-and-flip reference model.
// Counter expectations follow HAMMING_ARB_ERR_CNT_EN (zero when undefined).
module tb_hamming_decode_arbiter;
  localparam int CNT_W = 8;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic clk, rst;
  logic a_valid, a_ready, b_valid, b_ready;
  logic [7:0] a_code, b_code;
  logic out_valid, out_ready, out_src;
  logic [7:0] out_code;
  logic [3:0] out_data;
  logic [1:0] out_flag;
  logic [2:0] out_loc;
  logic cnt_clr;
  logic [CNT_W-1:0] sec_cnt, ded_cnt;

  int checks = 0;
  int failures = 0;
  int exp_sec = 0;
  int exp_ded = 0;

  hamming_decode_arbiter #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_code(a_code),
    .b_valid(b_valid), .b_ready(b_ready), .b_code(b_code),
    .out_valid(out_valid), .out_ready(out_ready), .out_src(out_src),
    .out_code(out_code), .out_data(out_data), .out_flag(out_flag), .out_loc(out_loc),
    .cnt_clr(cnt_clr), .sec_cnt(sec_cnt), .ded_cnt(ded_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (a_ready && b_ready) begin
        failures++;
        $display("FAIL ready_exclusive got a_ready=1 b_ready=1 exp at most one");
      end
    end
  end

  typedef struct packed {
    logic [7:0] code;
    logic [1:0] flag;
    logic [2:0] loc;
  } exp_t;

  // Parity bits sit at positions 1,2,4; a valid word has XOR of set-bit positions equal to 0.
  function automatic logic [7:0] encode(input logic [3:0] d);
    logic [7:0] c;
    logic [2:0] s;
    c = 8'd0;
    c[2] = d[0]; c[4] = d[1]; c[5] = d[2]; c[6] = d[3];
    s = 3'd0;
    for (int i = 0; i < 7; i++) if (c[i]) s = s ^ 3'(i + 1);
    c[0] = s[0]; c[1] = s[1]; c[3] = s[2];
    c[7] = ^c[6:0];
    return c;
  endfunction

  function automatic logic [7:0] rand_mask(input int n);
    logic [7:0] m;
    int b;
    m = 8'd0;
    while ($countones(m) < n) begin
      b = $urandom_range(0, 7);
      m[b] = 1'b1;
    end
    return m;
  endfunction

  function automatic exp_t model_dec(input logic [7:0] orig, input logic [7:0] fm);
    exp_t e;
    e.code = orig;
    e.flag = 2'b00;
    e.loc  = 3'd0;
    case ($countones(fm))
      1: begin
        e.flag = 2'b01;
        for (int i = 0; i < 7; i++) if (fm[i]) e.loc = 3'(i + 1);
      end
      2: begin
        e.code = orig ^ fm;
        e.flag = 2'b10;
      end
      default: ;
    endcase
    return e;
  endfunction

  function automatic logic [3:0] data_of(input logic [7:0] c);
    return {c[6], c[5], c[4], c[2]};
  endfunction

  task automatic model_count(input logic [1:0] flag);
    if (flag == 2'b01 && exp_sec < MAXC) exp_sec++;
    if (flag == 2'b10 && exp_ded < MAXC) exp_ded++;
  endtask

  function automatic logic [CNT_W-1:0] cnt_exp(input int v);
`ifdef HAMMING_ARB_ERR_CNT_EN
    return CNT_W'(v);
`else
    return '0;
`endif
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    a_valid = 1'b0; b_valid = 1'b0; out_ready = 1'b0; cnt_clr = 1'b0;
    exp_sec = 0; exp_ded = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Starts and ends at a negedge with the DUT idle and out_ready low.
  task automatic run_txn(input logic use_b, input logic [7:0] code,
                         output logic rdy, output int lat, output logic os,
                         output logic [7:0] oc, output logic [3:0] od,
                         output logic [1:0] of, output logic [2:0] ol);
    a_valid = ~use_b; b_valid = use_b;
    a_code = code; b_code = code;
    #1;
    rdy = use_b ? b_ready : a_ready;
    @(posedge clk);
    @(negedge clk);
    a_valid = 1'b0; b_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    os = out_src; oc = out_code; od = out_data; of = out_flag; ol = out_loc;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_valid = 1'b0; b_valid = 1'b0; out_ready = 1'b0; cnt_clr = 1'b0;
    a_code = 8'd0; b_code = 8'd0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_src !== 1'b0 || out_code !== 8'd0 || out_data !== 4'd0 ||
        out_flag !== 2'b00 || out_loc !== 3'd0) begin
      failures++;
      $display("FAIL reset_outputs got v=%b s=%b c=%h d=%h f=%b l=%0d exp all zero",
               out_valid, out_src, out_code, out_data, out_flag, out_loc);
    end
    checks++;
    if (sec_cnt !== '0 || ded_cnt !== '0) begin
      failures++;
      $display("FAIL reset_counters got sec=%0d ded=%0d exp 0 0", sec_cnt, ded_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready_idle got a=%b b=%b exp 0 0", a_ready, b_ready);
    end
  endtask

  task automatic test_basic();
    logic rdy, os; int lat; logic [7:0] oc; logic [3:0] od; logic [1:0] of; logic [2:0] ol;
    do_reset();
    run_txn(1'b0, 8'h00, rdy, lat, os, oc, od, of, ol);
    checks++;
    if (rdy !== 1'b1) begin failures++; $display("FAIL basic_ready got %b exp 1", rdy); end
    checks++;
    if (lat != 2) begin failures++; $display("FAIL basic_latency got %0d exp 2", lat); end
    checks++;
    if (os !== 1'b0 || oc !== 8'h00 || of !== 2'b00 || ol !== 3'd0 || od !== 4'h0) begin
      failures++;
      $display("FAIL basic_result got s=%b c=%h f=%b l=%0d d=%h exp 0 00 00 0 0", os, oc, of, ol, od);
    end
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_release got %b exp 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic srcs [4];
    exp_t got [4];
    int times [4];
    int n, cyc;
    exp_t e;
    do_reset();
    a_valid = 1'b1; b_valid = 1'b1; a_code = 8'h00; b_code = 8'h04; out_ready = 1'b1;
    #1;
    checks++;
    if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
      failures++;
      $display("FAIL tie_first_grant got a=%b b=%b exp 1 0", a_ready, b_ready);
    end
    n = 0; cyc = 0;
    while (n < 4 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (out_valid) begin
        srcs[n] = out_src;
        got[n] = '{code: out_code, flag: out_flag, loc: out_loc};
        times[n] = cyc;
        model_count(model_dec(8'h00, (n % 2 == 1) ? 8'h04 : 8'h00).flag);
        n++;
      end
    end
    a_valid = 1'b0; b_valid = 1'b0;
    checks++;
    if (n != 4) begin failures++; $display("FAIL tie_result_count got %0d exp 4", n); end
    for (int k = 0; k < n; k++) begin
      e = model_dec(8'h00, (k % 2 == 1) ? 8'h04 : 8'h00);
      checks++;
      if (srcs[k] !== k[0] || got[k] !== e) begin
        failures++;
        $display("FAIL tie_result_%0d got s=%b c=%h f=%b l=%0d exp s=%b c=%h f=%b l=%0d",
                 k, srcs[k], got[k].code, got[k].flag, got[k].loc, k[0], e.code, e.flag, e.loc);
      end
      if (k > 0) begin
        checks++;
        if (times[k] - times[k-1] != 3) begin
          failures++;
          $display("FAIL tie_period_%0d got %0d exp 3", k, times[k] - times[k-1]);
        end
      end
    end
    checks++;
    if (sec_cnt !== cnt_exp(exp_sec)) begin
      failures++;
      $display("FAIL tie_sec_cnt got %0d exp %0d", sec_cnt, cnt_exp(exp_sec));
    end
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_special();
    logic rdy, os; int lat; logic [7:0] oc; logic [3:0] od; logic [1:0] of; logic [2:0] ol;
    logic [7:0] masks [2];
    exp_t e;
    masks[0] = 8'h80; masks[1] = 8'h03;
    for (int k = 0; k < 2; k++) begin
      run_txn(1'b1, masks[k], rdy, lat, os, oc, od, of, ol);
      e = model_dec(8'h00, masks[k]);
      model_count(e.flag);
      checks++;
      if (oc !== e.code || of !== e.flag || ol !== e.loc || os !== 1'b1) begin
        failures++;
        $display("FAIL special_%h got c=%h f=%b l=%0d s=%b exp c=%h f=%b l=%0d s=1",
                 masks[k], oc, of, ol, os, e.code, e.flag, e.loc);
      end
      checks++;
      if (sec_cnt !== cnt_exp(exp_sec) || ded_cnt !== cnt_exp(exp_ded)) begin
        failures++;
        $display("FAIL special_cnt_%h got sec=%0d ded=%0d exp sec=%0d ded=%0d",
                 masks[k], sec_cnt, ded_cnt, cnt_exp(exp_sec), cnt_exp(exp_ded));
      end
    end
  endtask

  task automatic test_random();
    logic rdy, os; int lat; logic [7:0] oc; logic [3:0] od; logic [1:0] of; logic [2:0] ol;
    logic use_b; logic [7:0] orig, fm; exp_t e;
    for (int t = 0; t < 40; t++) begin
      use_b = 1'($urandom_range(0, 1));
      orig = encode(4'($urandom_range(0, 15)));
      fm = rand_mask($urandom_range(0, 2));
      run_txn(use_b, orig ^ fm, rdy, lat, os, oc, od, of, ol);
      e = model_dec(orig, fm);
      model_count(e.flag);
      checks++;
      if (rdy !== 1'b1 || lat != 2) begin
        failures++;
        $display("FAIL rand_handshake_%0d got rdy=%b lat=%0d exp 1 2", t, rdy, lat);
      end
      checks++;
      if (os !== use_b || oc !== e.code || od !== data_of(e.code) || of !== e.flag || ol !== e.loc) begin
        failures++;
        $display("FAIL rand_result_%0d in=%h got s=%b c=%h d=%h f=%b l=%0d exp s=%b c=%h d=%h f=%b l=%0d",
                 t, orig ^ fm, os, oc, od, of, ol, use_b, e.code, data_of(e.code), e.flag, e.loc);
      end
      checks++;
      if (sec_cnt !== cnt_exp(exp_sec) || ded_cnt !== cnt_exp(exp_ded)) begin
        failures++;
        $display("FAIL rand_cnt_%0d got sec=%0d ded=%0d exp sec=%0d ded=%0d",
                 t, sec_cnt, ded_cnt, cnt_exp(exp_sec), cnt_exp(exp_ded));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] orig, fm; exp_t e; int w;
    orig = encode(4'($urandom_range(0, 15)));
    fm = rand_mask(1);
    e = model_dec(orig, fm);
    out_ready = 1'b0;
    a_valid = 1'b1; a_code = orig ^ fm;
    @(posedge clk);
    @(negedge clk);
    b_valid = 1'b1; b_code = 8'h55;
    w = 0;
    while (!out_valid && w < 10) begin @(negedge clk); w++; end
    model_count(e.flag);
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (out_valid !== 1'b1 || out_code !== e.code || out_flag !== e.flag || out_loc !== e.loc ||
          out_src !== 1'b0 || a_ready !== 1'b0 || b_ready !== 1'b0) begin
        failures++;
        $display("FAIL hold_cycle_%0d got v=%b c=%h f=%b l=%0d s=%b ar=%b br=%b exp v=1 c=%h f=%b l=%0d s=0 ar=0 br=0",
                 c, out_valid, out_code, out_flag, out_loc, out_src, a_ready, b_ready, e.code, e.flag, e.loc);
      end
      @(negedge clk);
    end
    checks++;
    if (sec_cnt !== cnt_exp(exp_sec)) begin
      failures++;
      $display("FAIL hold_sec_cnt got %0d exp %0d", sec_cnt, cnt_exp(exp_sec));
    end
    out_ready = 1'b1;
    a_valid = 1'b0; b_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL hold_release got %b exp 0", out_valid); end
    b_valid = 1'b1;
    #1;
    checks++;
    if (b_ready !== 1'b1) begin failures++; $display("FAIL hold_back_idle got b_ready=%b exp 1", b_ready); end
    b_valid = 1'b0;
  endtask

  task automatic test_saturate();
    int n, cyc;
    do_reset();
    a_valid = 1'b1; a_code = 8'h04; out_ready = 1'b1;
    n = 0; cyc = 0;
    while (n < MAXC + 4 && cyc < 3 * (MAXC + 4) + 40) begin
      @(negedge clk);
      cyc++;
      if (out_valid) begin
        model_count(2'b01);
        n++;
      end
    end
    a_valid = 1'b0;
    checks++;
    if (n != MAXC + 4) begin failures++; $display("FAIL sat_word_count got %0d exp %0d", n, MAXC + 4); end
    checks++;
    if (sec_cnt !== cnt_exp(exp_sec) || ded_cnt !== '0) begin
      failures++;
      $display("FAIL sat_value got sec=%0d ded=%0d exp sec=%0d ded=0", sec_cnt, ded_cnt, cnt_exp(exp_sec));
    end
    @(negedge clk);
    out_ready = 1'b0;
    a_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_valid = 1'b0;
    cnt_clr = 1'b1;
    exp_sec = 0; exp_ded = 0;
    @(negedge clk);
    cnt_clr = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || sec_cnt !== '0) begin
      failures++;
      $display("FAIL clr_wins got v=%b sec=%0d exp v=1 sec=0", out_valid, sec_cnt);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int seen;
    logic rdy, os; int lat; logic [7:0] oc; logic [3:0] od; logic [1:0] of; logic [2:0] ol;
    run_txn(1'b0, 8'h03, rdy, lat, os, oc, od, of, ol);
    model_count(2'b10);
    a_valid = 1'b1; a_code = 8'h04;
    @(posedge clk);
    @(negedge clk);
    a_valid = 1'b0;
    rst = 1'b1;
    exp_sec = 0; exp_ded = 0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || sec_cnt !== '0 || ded_cnt !== '0 || out_code !== 8'd0 || out_flag !== 2'b00) begin
      failures++;
      $display("FAIL mid_reset got v=%b sec=%0d ded=%0d c=%h f=%b exp all zero",
               out_valid, sec_cnt, ded_cnt, out_code, out_flag);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checks++;
    if (seen != 0) begin failures++; $display("FAIL mid_no_result got %0d valid cycles exp 0", seen); end
    a_valid = 1'b1; b_valid = 1'b1;
    #1;
    checks++;
    if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
      failures++;
      $display("FAIL mid_tie_after_reset got a=%b b=%b exp 1 0", a_ready, b_ready);
    end
    a_valid = 1'b0; b_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_special();
    test_random();
    test_backpressure();
    test_saturate();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hamming_decode_arbiter.md
# hamming_decode_arbiter

Two-requester arbiter and sequencer for one shared SECDED(8,4) Hamming decode datapath. Two producers each present an 8-bit code word with a valid/ready handshake. A round-robin grant selects one word, which is registered, decoded by a single internal decoder instance, and held in an output register until the consumer accepts it. Optional saturating counters track corrected and uncorrectable errors for status readout.

## Interface
Parameters:
- CNT_W, default 8: width of each error counter.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- a_valid  in  1  requester A has a code word.
- a_ready  out  1  requester A word accepted this cycle.
- a_code  in  8  requester A code word, bit order [p_all,d3,d2,d1,p2,d0,p1,p0].
- b_valid, b_ready, b_code  in/out/in  1/1/8  requester B, same meaning as A.
- out_valid  out  1  decoded result available.
- out_ready  in  1  consumer accepts the result.
- out_src  out  1  source of the result: 0 = A, 1 = B.
- out_code  out  8  corrected code word. Passed through uncorrected on a double error.
- out_data  out  4  {d3,d2,d1,d0} taken from out_code, i.e. {out_code[6],out_code[5],out_code[4],out_code[2]}.
- out_flag  out  2  00 = no error, 01 = single error (corrected), 10 = double error.
- out_loc  out  3  syndrome position 1..7. 0 means no error, p_all error, or double error.
- cnt_clr  in  1  synchronous clear of both counters.
- sec_cnt  out  CNT_W  count of single-error results.
- ded_cnt  out  CNT_W  count of double-error results.

## Operation
- FSM states: IDLE, DEC, OUT. Reset state is IDLE.
- IDLE
  - Grant is computed combinationally from a_valid, b_valid and the last-served pointer `last`.
  - If only one requester is valid, that requester is granted.
  - If both are valid, the requester that is not `last` is granted.
  - The granted requester's ready signal is 1. All ready signals are 0 outside IDLE.
  - On a handshake (valid & ready): capture the code word into in_reg and the source into src_reg, update `last` to the granted requester, and go to DEC.
- DEC
  - The internal decoder evaluates in_reg.
  - Capture out_code, out_flag, out_loc and out_src into the output registers, then go to OUT.
- OUT
  - out_valid = 1.
  - The output registers hold stable while out_ready = 0.
  - On out_ready = 1, go to IDLE.
- Decode rules:
  - Syndrome bit s0 = p0 ^ d0 ^ d1 ^ d3.
  - Syndrome bit s1 = p1 ^ d0 ^ d2 ^ d3.
  - Syndrome bit s2 = p2 ^ d1 ^ d2 ^ d3.
  - Overall parity sp = XOR of all 8 bits.
  - sp = 1: single error. If s = 0, flip bit 7; otherwise flip bit s−1. out_flag = 01, out_loc = s.
  - sp = 0 and s ≠ 0: double error. No correction, out_flag = 10, out_loc = 0.
  - sp = 0 and s = 0: no error. out_flag = 00, out_loc = 0.
- Counters:
  - On the DEC→OUT transition, sec_cnt increments when the flag is 01 and ded_cnt increments when the flag is 10.
  - Each counter saturates at 2^CNT_W−1.
  - If cnt_clr and an increment occur in the same cycle, cnt_clr wins: the counter reads 0 on the next cycle.
- Reset values:
  - state = IDLE, `last` = B (so A wins the first tie).
  - out_valid = 0, out_src = 0, out_code = 0, out_data = 0, out_flag = 00, out_loc = 0.
  - in_reg = 0, counters = 0.
- Reset asserted mid-transaction abandons the word in flight. No result is emitted and the counters are zeroed.
- Valid signals that drop without a handshake are ignored. The arbiter holds no grant memory except `last`.

## Timing
- Handshake at edge N: out_valid rises after edge N+1 and is visible in the cycle following edge N+1.
- Latency is 2 clocks from accept to out_valid.
- Minimum period between accepts is 3 cycles (IDLE, DEC, OUT with out_ready held at 1).
- a_ready and b_ready are combinational from the valid signals and state. They are never both 1 in the same cycle.
- out_valid deasserts on the edge at which out_valid & out_ready are both 1.
- Counter values are visible the cycle after the DEC→OUT edge.

## Configuration
- HAMMING_ARB_ERR_CNT_EN defined: sec_cnt, ded_cnt and cnt_clr are implemented as described above.
- Macro undefined: the counter logic is removed. sec_cnt and ded_cnt are tied to 0, cnt_clr is ignored, and all ports remain present.

## Test plan
- Reset, then A sends 0x00 with out_ready = 1 → a_ready = 1; after 2 cycles out_valid = 1, out_src = 0, out_code = 0x00, out_flag = 00, out_loc = 0.
- A and B valid in the same cycle from reset, B code 0x00 with bit 2 flipped (0x04) → A is served first. B is served next with out_code = 0x00, out_flag = 01, out_loc = 3, and sec_cnt = 1.
- Word 0x80 (p_all error only) → out_code = 0x00, out_flag = 01, out_loc = 0.
- Word 0x03 (double error) → out_code = 0x03, out_flag = 10, out_loc = 0, ded_cnt increments.
- out_ready held at 0 for 5 cycles in OUT → outputs stable, a_ready = b_ready = 0; release out_ready → IDLE on the next edge.
- 2^CNT_W+3 single-error words → sec_cnt saturates at 255 (CNT_W = 8). cnt_clr coincident with an increment → sec_cnt = 0. rst asserted in DEC → out_valid = 0, counters = 0.
